// File: rtl/fetch_stage.sv
// Instruction fetch front end: owns the fetch PC, drives a 1-cycle-latency instruction
// memory and buffers returned {pc, instr} pairs in a small FIFO for decode.
module fetch_stage #(
  parameter int         DEPTH    = 2,
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  output logic       imem_rd,
  output logic [7:0] imem_addr,
  input  logic [7:0] imem_q,
  input  logic       redirect,
  input  logic [7:0] redirect_pc,
  output logic [7:0] instr,
  output logic [7:0] instr_pc,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [3:0] buf_count
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]    pc_p0;
  logic          vld_p1;
  logic [7:0]    pc_p1;
  logic [7:0]    buf_pc  [DEPTH];
  logic [7:0]    buf_ins [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [3:0]    count;
  logic [4:0]    credit;
  logic          pop;
  logic          push;
  logic          issue;
  logic          has_data;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A same-cycle pop frees a slot, so the issue test counts it as credit.
  assign has_data    = (count != 4'd0);
  assign instr_valid = has_data & ~redirect & ~reset;
  assign pop         = instr_valid & instr_ready;
  assign push        = vld_p1 & ~redirect;
  assign credit      = {1'b0, count} + {4'b0, vld_p1} - {4'b0, pop};
  assign issue       = ~reset & ~redirect & (credit < 5'(DEPTH));

  assign imem_rd   = issue;
  assign imem_addr = pc_p0;
  assign buf_count = count;
  assign instr     = has_data ? buf_ins[head] : 8'h00;
  assign instr_pc  = has_data ? buf_pc[head]  : 8'h00;

  // Stage p0 -> p1: fetch PC advance, in-flight tracking and FIFO bookkeeping
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_p0  <= RESET_PC;
      vld_p1 <= 1'b0;
      count  <= 4'd0;
      head   <= '0;
      tail   <= '0;
    end else if (redirect) begin
      pc_p0  <= redirect_pc;
      vld_p1 <= 1'b0;
      count  <= 4'd0;
      head   <= '0;
      tail   <= '0;
    end else begin
      vld_p1 <= issue;
      if (issue) pc_p0 <= pc_p0 + 8'd1;
      if (push)  tail  <= bump(tail);
      if (pop)   head  <= bump(head);
      count <= count + {3'b0, push} - {3'b0, pop};
    end
  end

  // Stage p1 -> buffer: capture the returning instruction with its address
  always_ff @(posedge clock) begin
    if (issue) pc_p1 <= pc_p0;
    if (push & ~reset) begin
      buf_pc[tail]  <= pc_p1;
      buf_ins[tail] <= imem_q;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed per-cycle vector table, then a randomized
// ready/redirect run checked against a program-order scoreboard.
module tb_fetch_stage;

  localparam bit T = 1'b1;
  localparam bit F = 1'b0;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       redirect = 1'b0;
  logic [7:0] redirect_pc = 8'h00;
  logic       instr_ready = 1'b0;

  logic       rd0, vld0, rd1, vld1;
  logic [7:0] addr0, ins0, ipc0, q0, addr1, ins1, ipc1, q1;
  logic [3:0] cnt0, cnt1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  fetch_stage #(.DEPTH(2), .RESET_PC(8'h00)) u0 (
    .clock(clock), .reset(reset), .imem_rd(rd0), .imem_addr(addr0), .imem_q(q0),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr(ins0), .instr_pc(ipc0),
    .instr_valid(vld0), .instr_ready(instr_ready), .buf_count(cnt0));

  fetch_stage #(.DEPTH(2), .RESET_PC(8'hFE)) u1 (
    .clock(clock), .reset(reset), .imem_rd(rd1), .imem_addr(addr1), .imem_q(q1),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr(ins1), .instr_pc(ipc1),
    .instr_valid(vld1), .instr_ready(instr_ready), .buf_count(cnt1));

  // Synchronous instruction memory holding mem[a] = a ^ A5
  always @(posedge clock) begin
    if (rd0) q0 <= addr0 ^ 8'hA5;
    if (rd1) q1 <= addr1 ^ 8'hA5;
  end

  typedef struct packed {
    logic       rst, rdy, rdr;
    logic [7:0] rpc;
    logic       e_rd;
    logic [7:0] e_addr;
    logic       e_vld;
    logic [7:0] e_ins, e_ipc;
    logic [3:0] e_cnt;
    logic       c1;
    logic [7:0] e1_addr, e1_ipc;
  } vec_t;

  function automatic vec_t mk(input bit rst, rdy, rdr, input logic [7:0] rpc,
                              input bit rd, input logic [7:0] addr, input bit vld,
                              input logic [7:0] ins, ipc, input logic [3:0] cnt,
                              input bit c1, input logic [7:0] a1, p1);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rdr = rdr; v.rpc = rpc;
    v.e_rd = rd; v.e_addr = addr; v.e_vld = vld; v.e_ins = ins; v.e_ipc = ipc;
    v.e_cnt = cnt; v.c1 = c1; v.e1_addr = a1; v.e1_ipc = p1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  vec_t tbl [33];
  logic [7:0] exp_pc;
  logic [7:0] held_ins, held_pc;
  bit         stalled;
  int         delivered;

  initial begin
    // rst rdy rdr rpc | rd addr vld ins ipc cnt | c1 u1_addr u1_ipc
    tbl[0]  = mk(T, T, F, 8'h00, F, 8'h00, F, 8'h00, 8'h00, 4'd0, T, 8'h00, 8'h00);
    tbl[1]  = mk(T, T, F, 8'h00, F, 8'h00, F, 8'h00, 8'h00, 4'd0, T, 8'h00, 8'h00);
    tbl[2]  = mk(F, T, F, 8'h00, T, 8'h00, F, 8'h00, 8'h00, 4'd0, T, 8'hFE, 8'h00);
    tbl[3]  = mk(F, T, F, 8'h00, T, 8'h01, F, 8'h00, 8'h00, 4'd0, T, 8'hFF, 8'h00);
    tbl[4]  = mk(F, T, F, 8'h00, T, 8'h02, T, 8'hA5, 8'h00, 4'd1, T, 8'h00, 8'hFE);
    tbl[5]  = mk(F, T, F, 8'h00, T, 8'h03, T, 8'hA4, 8'h01, 4'd1, T, 8'h01, 8'hFF);
    tbl[6]  = mk(F, T, F, 8'h00, T, 8'h04, T, 8'hA7, 8'h02, 4'd1, T, 8'h02, 8'h00);
    tbl[7]  = mk(F, T, F, 8'h00, T, 8'h05, T, 8'hA6, 8'h03, 4'd1, T, 8'h03, 8'h01);
    // backpressure from reset
    tbl[8]  = mk(T, F, F, 8'h00, F, 8'h00, F, 8'h00, 8'h00, 4'd0, F, 8'h00, 8'h00);
    tbl[9]  = mk(F, F, F, 8'h00, T, 8'h00, F, 8'h00, 8'h00, 4'd0, F, 8'h00, 8'h00);
    tbl[10] = mk(F, F, F, 8'h00, T, 8'h01, F, 8'h00, 8'h00, 4'd0, F, 8'h00, 8'h00);
    tbl[11] = mk(F, F, F, 8'h00, F, 8'h02, T, 8'hA5, 8'h00, 4'd1, F, 8'h00, 8'h00);
    tbl[12] = mk(F, F, F, 8'h00, F, 8'h02, T, 8'hA5, 8'h00, 4'd2, F, 8'h00, 8'h00);
    tbl[13] = mk(F, F, F, 8'h00, F, 8'h02, T, 8'hA5, 8'h00, 4'd2, F, 8'h00, 8'h00);
    tbl[14] = mk(F, T, F, 8'h00, T, 8'h02, T, 8'hA5, 8'h00, 4'd2, F, 8'h00, 8'h00);
    tbl[15] = mk(F, T, F, 8'h00, T, 8'h03, T, 8'hA4, 8'h01, 4'd1, F, 8'h00, 8'h00);
    tbl[16] = mk(F, T, F, 8'h00, T, 8'h04, T, 8'hA7, 8'h02, 4'd1, F, 8'h00, 8'h00);
    tbl[17] = mk(F, T, F, 8'h00, T, 8'h05, T, 8'hA6, 8'h03, 4'd1, F, 8'h00, 8'h00);
    // redirect with one buffered entry and a read in flight
    tbl[18] = mk(F, F, T, 8'h40, F, 8'h06, F, 8'h00, 8'h00, 4'd1, F, 8'h00, 8'h00);
    tbl[19] = mk(F, F, F, 8'h00, T, 8'h40, F, 8'h00, 8'h00, 4'd0, F, 8'h00, 8'h00);
    tbl[20] = mk(F, F, F, 8'h00, T, 8'h41, F, 8'h00, 8'h00, 4'd0, F, 8'h00, 8'h00);
    tbl[21] = mk(F, F, F, 8'h00, F, 8'h42, T, 8'hE5, 8'h40, 4'd1, F, 8'h00, 8'h00);
    tbl[22] = mk(F, T, F, 8'h00, T, 8'h42, T, 8'hE5, 8'h40, 4'd2, F, 8'h00, 8'h00);
    tbl[23] = mk(F, T, F, 8'h00, T, 8'h43, T, 8'hE4, 8'h41, 4'd1, F, 8'h00, 8'h00);
    // back-to-back redirects: last one wins
    tbl[24] = mk(F, T, T, 8'h80, F, 8'h44, F, 8'h00, 8'h00, 4'd1, F, 8'h00, 8'h00);
    tbl[25] = mk(F, T, T, 8'h90, F, 8'h80, F, 8'h00, 8'h00, 4'd0, F, 8'h00, 8'h00);
    tbl[26] = mk(F, T, F, 8'h00, T, 8'h90, F, 8'h00, 8'h00, 4'd0, F, 8'h00, 8'h00);
    tbl[27] = mk(F, T, F, 8'h00, T, 8'h91, F, 8'h00, 8'h00, 4'd0, F, 8'h00, 8'h00);
    tbl[28] = mk(F, T, F, 8'h00, T, 8'h92, T, 8'h35, 8'h90, 4'd1, F, 8'h00, 8'h00);
    // reset one cycle after an issue
    tbl[29] = mk(T, T, F, 8'h00, F, 8'h00, F, 8'h00, 8'h00, 4'd0, F, 8'h00, 8'h00);
    tbl[30] = mk(F, T, F, 8'h00, T, 8'h00, F, 8'h00, 8'h00, 4'd0, F, 8'h00, 8'h00);
    tbl[31] = mk(F, T, F, 8'h00, T, 8'h01, F, 8'h00, 8'h00, 4'd0, F, 8'h00, 8'h00);
    tbl[32] = mk(F, T, F, 8'h00, T, 8'h02, T, 8'hA5, 8'h00, 4'd1, F, 8'h00, 8'h00);

    for (int i = 0; i < 33; i++) begin
      @(negedge clock);
      reset       = tbl[i].rst;
      instr_ready = tbl[i].rdy;
      redirect    = tbl[i].rdr;
      redirect_pc = tbl[i].rpc;
      #1;
      chk($sformatf("row%0d imem_rd", i), 8'(rd0), 8'(tbl[i].e_rd));
      chk($sformatf("row%0d instr_valid", i), 8'(vld0), 8'(tbl[i].e_vld));
      if (!tbl[i].rst) begin
        chk($sformatf("row%0d imem_addr", i), addr0, tbl[i].e_addr);
        chk($sformatf("row%0d buf_count", i), 8'(cnt0), 8'(tbl[i].e_cnt));
      end
      if (tbl[i].e_vld) begin
        chk($sformatf("row%0d instr", i), ins0, tbl[i].e_ins);
        chk($sformatf("row%0d instr_pc", i), ipc0, tbl[i].e_ipc);
      end
      if (tbl[i].c1) begin
        chk($sformatf("row%0d wrap imem_rd", i), 8'(rd1), 8'(tbl[i].e_rd));
        chk($sformatf("row%0d wrap instr_valid", i), 8'(vld1), 8'(tbl[i].e_vld));
        if (!tbl[i].rst) chk($sformatf("row%0d wrap imem_addr", i), addr1, tbl[i].e1_addr);
        if (tbl[i].e_vld) begin
          chk($sformatf("row%0d wrap instr_pc", i), ipc1, tbl[i].e1_ipc);
          chk($sformatf("row%0d wrap instr", i), ins1, tbl[i].e1_ipc ^ 8'hA5);
        end
      end
    end

    // Random ready/redirect run against a program-order scoreboard
    @(negedge clock);
    reset = 1'b0; redirect = 1'b1; redirect_pc = 8'h10; instr_ready = 1'b0;
    #1;
    chk("rand start instr_valid", 8'(vld0), 8'h00);
    exp_pc = 8'h10;
    stalled = 1'b0;
    delivered = 0;
    held_ins = 8'h00;
    held_pc = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      instr_ready = 1'($urandom_range(0, 1));
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = 8'($urandom_range(0, 255));
      #1;
      if (stalled && vld0) begin
        chk("stall instr stable", ins0, held_ins);
        chk("stall instr_pc stable", ipc0, held_pc);
      end
      if (redirect) begin
        chk("redirect instr_valid", 8'(vld0), 8'h00);
        chk("redirect imem_rd", 8'(rd0), 8'h00);
        exp_pc = redirect_pc;
      end else if (vld0 && instr_ready) begin
        chk("order instr_pc", ipc0, exp_pc);
        chk("order instr", ins0, exp_pc ^ 8'hA5);
        exp_pc = exp_pc + 8'd1;
        delivered++;
      end
      chk("occupancy bound", 8'(cnt0 <= 4'd2), 8'h01);
      stalled  = vld0 && !instr_ready;
      held_ins = ins0;
      held_pc  = ipc0;
    end
    chk("rand progress", 8'(delivered > 300), 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
